// File: rtl/w0rm_core_interrupt_ctrl_pkg.sv
// rtl/w0rm_core_interrupt_ctrl_pkg.sv - shared constants and types for the W0RM interrupt controller
package w0rm_core_interrupt_ctrl_pkg;

    // Vector number width: vector 0 (core) plus up to 63 peripheral lines
    localparam int VEC_W = 6;

    // Non-maskable core interrupt always owns vector 0
    localparam logic [VEC_W-1:0] CORE_VEC = '0;

    // Register word offsets; enable and pending words sit just past the vector table
    localparam int VEC_BASE    = 0;
    localparam int ENABLE_OFS  = 1;
    localparam int PENDING_OFS = 2;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } irq_state_e;

endpackage

// File: rtl/w0rm_irq_ctx_stack.sv
// rtl/w0rm_irq_ctx_stack.sv - LIFO of saved {level, r0-r3, pc} contexts for nested ISRs
module w0rm_irq_ctx_stack #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int LEVEL_W    = 6,
    localparam int ENTRY_W   = LEVEL_W + 5 * DATA_WIDTH,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] push_data,
    output logic [ENTRY_W-1:0] top_data,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wr_ptr   = PTR_W'(count);
    assign rd_ptr   = PTR_W'(count - CNT_W'(1));
    assign top_data = mem[rd_ptr];

    // Occupancy count; overflow/underflow requests are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage needs no reset: only slots below count are ever read
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/w0rm_core_interrupt_ctrl.sv
// rtl/w0rm_core_interrupt_ctrl.sv - nesting, tail-chaining interrupt controller for the W0RM core
module w0rm_core_interrupt_ctrl
    import w0rm_core_interrupt_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_IRQ        = 16,
    parameter int NEST_DEPTH     = 4,
    parameter int CFG_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      core_interrupt,
    input  logic [NUM_IRQ-1:0]        irq_lines,
    output logic                      isr_addr_valid,
    output logic [ADDR_WIDTH-1:0]     isr_addr,
    output logic [VEC_W-1:0]          isr_number,
    input  logic                      isr_return,
    input  logic [DATA_WIDTH-1:0]     r0_in,
    input  logic [DATA_WIDTH-1:0]     r1_in,
    input  logic [DATA_WIDTH-1:0]     r2_in,
    input  logic [DATA_WIDTH-1:0]     r3_in,
    input  logic [DATA_WIDTH-1:0]     pc_in,
    output logic                      isr_restore,
    output logic [DATA_WIDTH-1:0]     r0_out,
    output logic [DATA_WIDTH-1:0]     r1_out,
    output logic [DATA_WIDTH-1:0]     r2_out,
    output logic [DATA_WIDTH-1:0]     r3_out,
    output logic [DATA_WIDTH-1:0]     pc_out,
    input  logic                      cfg_write,
    input  logic                      cfg_read,
    input  logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0]     cfg_wdata,
    output logic [DATA_WIDTH-1:0]     cfg_rdata,
    output logic                      cfg_rvalid
);

    localparam int NV      = NUM_IRQ + 1;
    localparam int VIW     = $clog2(NV);
    localparam int ENTRY_W = VEC_W + 5 * DATA_WIDTH;
    localparam int CNT_W   = $clog2(NEST_DEPTH + 1);
    localparam int DW      = DATA_WIDTH;

    irq_state_e          state;
    logic [NV-1:0]       src, src_q, pending, enable, eligible, clr_mask;
    logic [ADDR_WIDTH-1:0] vec_table [NV];
    logic                best_valid;
    logic [VEC_W-1:0]    best_vec;
    logic                ret_active, chain, pop, push, preempt_ok, take;
    logic [ENTRY_W-1:0]  stk_push, stk_top;
    logic [CNT_W-1:0]    stk_count;
    logic                stk_full, stk_empty;
    logic [VEC_W-1:0]    top_level;
    logic [31:0]         cfg_idx, cfg_vofs;
    logic                cfg_is_vec;
    logic [DW-1:0]       rd_word;

    assign src = {irq_lines, core_interrupt};

    // Masking gates eligibility only; the core vector ignores every enable
    always_comb begin
        eligible = pending & enable & {NV{enable[0]}};
        eligible[CORE_VEC] = pending[CORE_VEC];
    end

    // Fixed-priority encoder: lowest eligible vector number wins
    always_comb begin
        best_valid = 1'b0;
        best_vec   = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                best_valid = 1'b1;
                best_vec   = VEC_W'(i);
            end
        end
    end

    assign top_level  = stk_top[ENTRY_W-1 -: VEC_W];
    assign ret_active = (state == ST_ACTIVE) && isr_return;
    // On return, chain only if the winner would have preempted whatever lies underneath
    assign chain      = ret_active && best_valid &&
                        ((stk_count == CNT_W'(1)) || (best_vec < top_level));
    assign pop        = ret_active && !chain && !stk_empty;
    assign preempt_ok = (state == ST_ACTIVE) && !isr_return && best_valid &&
                        (best_vec < isr_number) && !stk_full;
    assign push       = ((state == ST_IDLE) && best_valid) || preempt_ok;
    assign take       = push || chain;
    assign clr_mask   = take ? (NV'(1) << best_vec) : '0;
    assign stk_push   = {isr_number, r0_in, r1_in, r2_in, r3_in, pc_in};

    w0rm_irq_ctx_stack #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NEST_DEPTH),
        .LEVEL_W    (VEC_W)
    ) u_ctx_stack (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .push_data  (stk_push),
        .top_data   (stk_top),
        .count      (stk_count),
        .full       (stk_full),
        .empty      (stk_empty)
    );

    // Rising-edge capture; a new edge beats a same-cycle take clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q   <= '0;
            pending <= '0;
        end else begin
            src_q   <= src;
            pending <= (pending & ~clr_mask) | (src & ~src_q);
        end
    end

    assign cfg_idx    = 32'(cfg_addr);
    assign cfg_vofs   = cfg_idx - 32'(VEC_BASE);
    assign cfg_is_vec = (cfg_vofs < 32'(NV));

    // Config read mux; anything outside the map reads as zero
    always_comb begin
        rd_word = '0;
        if (cfg_is_vec) begin
            rd_word = DW'(vec_table[cfg_vofs[VIW-1:0]]);
        end else if (cfg_idx == 32'(NUM_IRQ + ENABLE_OFS)) begin
            rd_word = DW'(enable);
        end else if (cfg_idx == 32'(NUM_IRQ + PENDING_OFS)) begin
            rd_word = DW'(pending);
        end
    end

    // Vector table survives reset so firmware-installed handlers persist
    always_ff @(posedge clk) begin
        if (cfg_write && cfg_is_vec) begin
            vec_table[cfg_vofs[VIW-1:0]] <= ADDR_WIDTH'(cfg_wdata);
        end
    end

    // Enable register and registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable     <= '0;
            cfg_rdata  <= '0;
            cfg_rvalid <= 1'b0;
        end else begin
            cfg_rvalid <= cfg_read;
            if (cfg_read) begin
                cfg_rdata <= rd_word;
            end
            if (cfg_write && (cfg_idx == 32'(NUM_IRQ + ENABLE_OFS))) begin
                enable <= NV'(cfg_wdata);
            end
        end
    end

    // Control FSM: take/preempt/tail-chain issue a vector, return without chain restores
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            isr_addr_valid <= 1'b0;
            isr_addr       <= '0;
            isr_number     <= '0;
            isr_restore    <= 1'b0;
            r0_out         <= '0;
            r1_out         <= '0;
            r2_out         <= '0;
            r3_out         <= '0;
            pc_out         <= '0;
        end else begin
            isr_addr_valid <= 1'b0;
            isr_restore    <= 1'b0;
            if (take) begin
                isr_addr_valid <= 1'b1;
                isr_addr       <= vec_table[best_vec[VIW-1:0]];
                isr_number     <= best_vec;
                state          <= ST_ACTIVE;
            end else if (pop) begin
                isr_restore <= 1'b1;
                r0_out      <= stk_top[5*DW-1 -: DW];
                r1_out      <= stk_top[4*DW-1 -: DW];
                r2_out      <= stk_top[3*DW-1 -: DW];
                r3_out      <= stk_top[2*DW-1 -: DW];
                pc_out      <= stk_top[DW-1:0];
                isr_number  <= top_level;
                if (stk_count == CNT_W'(1)) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_w0rm_core_interrupt_ctrl.sv
// tb/tb_w0rm_core_interrupt_ctrl.sv - directed self-checking bench for w0rm_core_interrupt_ctrl
module tb_w0rm_core_interrupt_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NI = 16;
    localparam int ND = 2;
    localparam int CW = 8;
    localparam int EN_W = NI + 1;
    localparam int PN_W = NI + 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          core_interrupt;
    logic [NI-1:0] irq_lines;
    logic          isr_addr_valid;
    logic [AW-1:0] isr_addr;
    logic [5:0]    isr_number;
    logic          isr_return;
    logic [DW-1:0] r0_in, r1_in, r2_in, r3_in, pc_in;
    logic          isr_restore;
    logic [DW-1:0] r0_out, r1_out, r2_out, r3_out, pc_out;
    logic          cfg_write, cfg_read;
    logic [CW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata, cfg_rdata;
    logic          cfg_rvalid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    w0rm_core_interrupt_ctrl #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_IRQ        (NI),
        .NEST_DEPTH     (ND),
        .CFG_ADDR_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .core_interrupt (core_interrupt),
        .irq_lines      (irq_lines),
        .isr_addr_valid (isr_addr_valid),
        .isr_addr       (isr_addr),
        .isr_number     (isr_number),
        .isr_return     (isr_return),
        .r0_in          (r0_in),
        .r1_in          (r1_in),
        .r2_in          (r2_in),
        .r3_in          (r3_in),
        .pc_in          (pc_in),
        .isr_restore    (isr_restore),
        .r0_out         (r0_out),
        .r1_out         (r1_out),
        .r2_out         (r2_out),
        .r3_out         (r3_out),
        .pc_out         (pc_out),
        .cfg_write      (cfg_write),
        .cfg_read       (cfg_read),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdata      (cfg_rdata),
        .cfg_rvalid     (cfg_rvalid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cfg_wr(input int a, input logic [31:0] d);
        cfg_write = 1'b1;
        cfg_addr  = CW'(a);
        cfg_wdata = d;
        step();
        cfg_write = 1'b0;
    endtask

    task automatic cfg_rd_check(input string tag, input int a, input logic [31:0] exp);
        cfg_read = 1'b1;
        cfg_addr = CW'(a);
        step();
        cfg_read = 1'b0;
        check({tag, "_rvalid"}, 64'(cfg_rvalid), 64'd1);
        check(tag, 64'(cfg_rdata), 64'(exp));
    endtask

    task automatic set_ctx(input logic [31:0] base);
        r0_in = base;
        r1_in = base + 32'd1;
        r2_in = base + 32'd2;
        r3_in = base + 32'd3;
        pc_in = base + 32'h100;
    endtask

    // Edge on line k; returns one cycle later with the line low again and the bit now pending
    task automatic pulse_irq(input int k);
        irq_lines[k] = 1'b1;
        step();
        irq_lines[k] = 1'b0;
    endtask

    task automatic ret();
        isr_return = 1'b1;
        step();
        isr_return = 1'b0;
    endtask

    task automatic check_take(input string tag, input int num, input logic [31:0] addr);
        check({tag, "_valid"}, 64'(isr_addr_valid), 64'd1);
        check({tag, "_num"}, 64'(isr_number), 64'(num));
        check({tag, "_addr"}, 64'(isr_addr), 64'(addr));
        check({tag, "_norst"}, 64'(isr_restore), 64'd0);
    endtask

    task automatic check_restore(input string tag, input int num, input logic [31:0] base);
        check({tag, "_restore"}, 64'(isr_restore), 64'd1);
        check({tag, "_novalid"}, 64'(isr_addr_valid), 64'd0);
        check({tag, "_num"}, 64'(isr_number), 64'(num));
        check({tag, "_r0"}, 64'(r0_out), 64'(base));
        check({tag, "_r3"}, 64'(r3_out), 64'(base + 32'd3));
        check({tag, "_pc"}, 64'(pc_out), 64'(base + 32'h100));
    endtask

    initial begin
        reset_n = 1'b0; core_interrupt = 1'b0; irq_lines = '0; isr_return = 1'b0;
        cfg_write = 1'b0; cfg_read = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        set_ctx(32'h0);
        step(); step();
        check("rst_valid", 64'(isr_addr_valid), 64'd0);
        check("rst_num", 64'(isr_number), 64'd0);
        check("rst_rvalid", 64'(cfg_rvalid), 64'd0);
        check("rst_restore", 64'(isr_restore), 64'd0);
        reset_n = 1'b1;
        step();
        cfg_rd_check("rst_enable", EN_W, 32'h0);
        cfg_rd_check("rst_pending", PN_W, 32'h0);

        // Basic take and restore through vector 3
        cfg_wr(3, 32'h400);
        cfg_wr(EN_W, 32'h9);
        set_ctx(32'hA000_0000);
        pulse_irq(2);
        check("t1_early", 64'(isr_addr_valid), 64'd0);
        step();
        check_take("t1", 3, 32'h400);
        set_ctx(32'h5555_0000);
        ret();
        check_restore("t1", 0, 32'hA000_0000);
        step();
        check("t1_pulse", 64'(isr_restore), 64'd0);

        // Masked capture, then enable releases it
        cfg_wr(6, 32'h600);
        pulse_irq(5);
        step();
        check("t2_masked", 64'(isr_addr_valid), 64'd0);
        cfg_rd_check("t2_pending", PN_W, 32'h40);
        set_ctx(32'hB100_0000);
        cfg_wr(EN_W, 32'h49);
        check("t2_notyet", 64'(isr_addr_valid), 64'd0);
        step();
        check_take("t2", 6, 32'h600);

        // Preempt ISR 6 with vector 1, unwind twice
        cfg_wr(1, 32'h100);
        cfg_wr(EN_W, 32'h4B);
        set_ctx(32'hB200_0000);
        pulse_irq(0);
        step();
        check_take("t3", 1, 32'h100);
        ret();
        check_restore("t3a", 6, 32'hB200_0000);
        ret();
        check_restore("t3b", 0, 32'hB100_0000);

        // Stack full holds vector 1, then it tail-chains on return
        set_ctx(32'hC100_0000);
        pulse_irq(5);
        step();
        check_take("t4a", 6, 32'h600);
        set_ctx(32'hC200_0000);
        pulse_irq(2);
        step();
        check_take("t4b", 3, 32'h400);
        set_ctx(32'hC300_0000);
        pulse_irq(0);
        step();
        check("t4_held", 64'(isr_addr_valid), 64'd0);
        cfg_rd_check("t4_pending", PN_W, 32'h2);
        check("t4_held2", 64'(isr_addr_valid), 64'd0);
        ret();
        check_take("t4_chain", 1, 32'h100);
        ret();
        check_restore("t4c", 6, 32'hC200_0000);
        ret();
        check_restore("t4d", 0, 32'hC100_0000);

        // Simultaneous lines 1 and 3: vector 2 first, vector 4 chained
        cfg_wr(2, 32'h200);
        cfg_wr(4, 32'h4400);
        cfg_wr(EN_W, 32'h1F);
        set_ctx(32'hD000_0000);
        irq_lines[1] = 1'b1;
        irq_lines[3] = 1'b1;
        step();
        irq_lines = '0;
        step();
        check_take("t5a", 2, 32'h200);
        ret();
        check_take("t5_chain", 4, 32'h4400);
        ret();
        check_restore("t5", 0, 32'hD000_0000);

        // Core interrupt ignores global enable
        cfg_wr(EN_W, 32'h0);
        cfg_wr(0, 32'h80);
        set_ctx(32'hE000_0000);
        core_interrupt = 1'b1;
        step();
        core_interrupt = 1'b0;
        step();
        check_take("t6_core", 0, 32'h80);
        ret();
        check_restore("t6_core", 0, 32'hE000_0000);

        // Register map edges
        cfg_wr(PN_W, 32'hFFFF);
        cfg_rd_check("pend_ro", PN_W, 32'h0);
        cfg_rd_check("oob_rd", 40, 32'h0);
        cfg_rd_check("vec3_rd", 3, 32'h400);
        cfg_rd_check("en_rd", EN_W, 32'h0);

        // Asynchronous reset in the middle of an ISR
        cfg_wr(EN_W, 32'h9);
        set_ctx(32'hF000_0000);
        pulse_irq(2);
        step();
        check_take("t7_pre", 3, 32'h400);
        reset_n = 1'b0;
        #1;
        check("t7_rst_valid", 64'(isr_addr_valid), 64'd0);
        check("t7_rst_addr", 64'(isr_addr), 64'd0);
        check("t7_rst_num", 64'(isr_number), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        ret();
        check("t7_ret_ign_rst", 64'(isr_restore), 64'd0);
        check("t7_ret_ign_val", 64'(isr_addr_valid), 64'd0);
        cfg_rd_check("t7_en_cleared", EN_W, 32'h0);
        cfg_wr(EN_W, 32'h9);
        set_ctx(32'hF100_0000);
        pulse_irq(2);
        step();
        check_take("t7_post", 3, 32'h400);
        ret();
        check_restore("t7_post", 0, 32'hF100_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
